ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, SHALL set storage to 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal 1..15, SHALL set the number of cycles readyOut is held low per access.
REQ-003 Port clk, input, 1: single clock; all state SHALL change only on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port dataIn, input, 32: write data from the memory stage.
REQ-006 Port addrIn, input, 32: byte address; word index = addrIn[DEPTH_LOG2+1:2], addrIn[1:0] ignored.
REQ-007 Port rwIn, input, 1: 1 = write, 0 = read.
REQ-008 Port triggerIn, input, 1: two-phase request; every toggle is one request.
REQ-009 Port dataOut, output, 32: read data, registered.
REQ-010 Port readyOut, output, 1: level; 1 = idle and last result valid.
REQ-011 Port errOut, output, 1: last access out of range (meaningful only with RAM_RESP_RANGE_CHECK_EN).

Function
REQ-012 triggerIn SHALL pass through two sync flops s1, s2; accepted phase register acc; request pending when s2 != acc.
REQ-013 FSM states SHALL be IDLE and BUSY, plus a down-counter cnt of 4 bits.
REQ-014 In IDLE with pending request: latch addrIn, dataIn, rwIn; set acc = s2; readyOut = 0 and cnt = LATENCY-1 next cycle; go to BUSY.
REQ-015 In BUSY with cnt != 0: decrement cnt; no storage access.
REQ-016 In BUSY with cnt == 0: perform access on latched values; next cycle readyOut = 1, dataOut and errOut updated, state IDLE.
REQ-017 Read SHALL load dataOut with the addressed word; write SHALL store the latched data and load dataOut with that same data.
REQ-018 readyOut SHALL be low for exactly LATENCY cycles per access; toggle-to-readyOut-fall latency is 3 cycles (2 sync + 1 accept).
REQ-019 The initiator SHALL hold addrIn, dataIn and rwIn stable from its toggle until readyOut returns high; the block samples them only at acceptance.
REQ-020 A toggle arriving during BUSY SHALL stay pending (acc unchanged) and be accepted on the first IDLE cycle, giving readyOut high for exactly one cycle between accesses.
REQ-021 Two toggles within one BUSY period cancel and are lost; this is a protocol violation and is not flagged.
REQ-022 Read and write to the same word in back-to-back accesses SHALL return the newly written data.

Reset
REQ-023 reset SHALL force state IDLE, cnt = 0, s1 = s2 = acc = 0, readyOut = 1, dataOut = 0, errOut = 0.
REQ-024 reset during BUSY SHALL abort the access; no write is committed.
REQ-025 Storage contents SHALL NOT be cleared by reset.
REQ-026 The initiator SHALL hold triggerIn = 0 while reset is high.

Configuration
REQ-027 With RAM_RESP_RANGE_CHECK_EN defined: addrIn[31:DEPTH_LOG2+2] != 0 is out of range; errOut = 1, write suppressed, read returns dataOut = 0.
REQ-028 Without RAM_RESP_RANGE_CHECK_EN: upper address bits are ignored (address wraps modulo depth) and errOut is tied to 0.

Verification (DEPTH_LOG2 = 8, LATENCY = 2 unless stated)
REQ-029 Write 0xDEADBEEF to 0x00000010, toggle 0->1 -> readyOut falls 3 cycles later, low 2 cycles, rises with dataOut = 0xDEADBEEF; then read 0x00000010, toggle 1->0 -> dataOut = 0xDEADBEEF.
REQ-030 Read 0x00000012 after the write above -> dataOut = 0xDEADBEEF (byte bits ignored).
REQ-031 Write 0x00000001 to 0x00000400 -> with macro: errOut = 1, word 0 unchanged, dataOut = 0; without macro: word 0 = 0x00000001, errOut = 0.
REQ-032 Toggle again 1 cycle after readyOut falls -> second access served, readyOut high exactly 1 cycle between the two low periods.
REQ-033 Assert reset in the second BUSY cycle of a write of 0x12345678 to 0x00000020 -> readyOut = 1 next cycle, dataOut = 0, later read of 0x00000020 returns the prior contents.
REQ-034 LATENCY = 1: read -> readyOut low for exactly 1 cycle, correct dataOut.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM behind a two-phase (toggle) request handshake.
// Each toggle of triggerIn is synchronised, accepted once idle, and served after
// LATENCY cycles with readyOut held low. Optional address range checking is
// enabled by defining RAM_RESP_RANGE_CHECK_EN.
module ram_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataIn,
    input  logic [31:0] addrIn,
    input  logic        rwIn,
    input  logic        triggerIn,
    output logic [31:0] dataOut,
    output logic        readyOut,
    output logic        errOut
);

    localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   s1_q, s2_q;
    logic                   acc_q, acc_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic [31:0]            data_q, data_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   rw_q, rw_d;
    logic                   mem_we;
    logic [31:0]            rd_word;
    logic [31:0]            mem_q [WORDS];
    logic                   unused_addr_bits;

`ifdef RAM_RESP_RANGE_CHECK_EN
    logic                   oor_q, oor_d;
    logic                   err_q, err_d;
    logic                   addr_oor;

    assign addr_oor         = |addrIn[31:DEPTH_LOG2+2];
    assign unused_addr_bits = ^addrIn[1:0];
    assign errOut           = err_q;
`else
    // Upper address bits are dropped, so accesses wrap modulo the depth.
    assign unused_addr_bits = ^{addrIn[31:DEPTH_LOG2+2], addrIn[1:0]};
    assign errOut           = 1'b0;
`endif

    assign rd_word  = mem_q[idx_q];
    assign dataOut  = data_q;
    assign readyOut = ready_q;

    // Two-flop synchroniser for the toggle request line.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= triggerIn;
            s2_q <= s1_q;
        end
    end

    // Control state, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            data_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
`ifdef RAM_RESP_RANGE_CHECK_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
`ifdef RAM_RESP_RANGE_CHECK_EN
            oor_q   <= oor_d;
            err_q   <= err_d;
`endif
        end
    end

    // Storage write port; never cleared, and a reset in the final BUSY cycle blocks the commit.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state logic: accept a pending toggle when idle, count down, then perform the access.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        data_d  = data_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        mem_we  = 1'b0;
`ifdef RAM_RESP_RANGE_CHECK_EN
        oor_d   = oor_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (s2_q != acc_q) begin
                    acc_d   = s2_q;
                    idx_d   = addrIn[DEPTH_LOG2+1:2];
                    wdata_d = dataIn;
                    rw_d    = rwIn;
`ifdef RAM_RESP_RANGE_CHECK_EN
                    oor_d   = addr_oor;
`endif
                    ready_d = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    state_d = IDLE;
`ifdef RAM_RESP_RANGE_CHECK_EN
                    err_d   = oor_q;
                    if (oor_q) begin
                        data_d = '0;
                    end else if (rw_q) begin
                        mem_we = 1'b1;
                        data_d = wdata_q;
                    end else begin
                        data_d = rd_word;
                    end
`else
                    if (rw_q) begin
                        mem_we = 1'b1;
                        data_d = wdata_q;
                    end else begin
                        data_d = rd_word;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed testbench for ram_responder: one task per scenario, inline checks.
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        resetA, resetB;
    logic        trigA, trigB;
    logic        rwIn;
    logic [31:0] dataIn, addrIn;
    logic [31:0] dataA, dataB;
    logic        readyA, readyB, errA, errB;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    ram_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut_a (
        .clk(clk), .reset(resetA), .dataIn(dataIn), .addrIn(addrIn), .rwIn(rwIn),
        .triggerIn(trigA), .dataOut(dataA), .readyOut(readyA), .errOut(errA)
    );

    ram_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
        .clk(clk), .reset(resetB), .dataIn(dataIn), .addrIn(addrIn), .rwIn(rwIn),
        .triggerIn(trigB), .dataOut(dataB), .readyOut(readyB), .errOut(errB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access by toggling the selected DUT's trigger; report cycles from toggle
    // to readyOut falling (-1 if it never falls) and how many cycles it stayed low.
    task automatic access(input logic sel, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data, output int fall_lat, output int low_cnt);
        logic rdy;
        rwIn = rw; addrIn = addr; dataIn = data;
        if (sel) trigB = ~trigB; else trigA = ~trigA;
        fall_lat = -1;
        low_cnt  = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            rdy = sel ? readyB : readyA;
            if (fall_lat < 0) begin
                if (!rdy) begin
                    fall_lat = i;
                    low_cnt  = 1;
                end
            end else if (!rdy) begin
                low_cnt++;
            end else begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetA = 1'b1; resetB = 1'b1; trigA = 1'b0; trigB = 1'b0;
        rwIn = 1'b0; addrIn = '0; dataIn = '0;
        repeat (3) tick();
        resetA = 1'b0; resetB = 1'b0;
        tick();
        tests_run++; if (readyA !== 1'b1) begin fails++; $display("FAIL reset_ready_a got %b want 1", readyA); end
        tests_run++; if (dataA !== 32'h0) begin fails++; $display("FAIL reset_data_a got %h want 00000000", dataA); end
        tests_run++; if (errA !== 1'b0) begin fails++; $display("FAIL reset_err_a got %b want 0", errA); end
        tests_run++; if (readyB !== 1'b1) begin fails++; $display("FAIL reset_ready_b got %b want 1", readyB); end
        tests_run++; if (dataB !== 32'h0) begin fails++; $display("FAIL reset_data_b got %h want 00000000", dataB); end
        repeat (4) tick();
        tests_run++; if (readyA !== 1'b1) begin fails++; $display("FAIL idle_ready_a got %b want 1", readyA); end
    endtask

    task automatic test_write_read();
        int fl, lc;
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, fl, lc);
        tests_run++; if (fl !== 3) begin fails++; $display("FAIL wr_fall_latency got %0d want 3", fl); end
        tests_run++; if (lc !== 2) begin fails++; $display("FAIL wr_low_cycles got %0d want 2", lc); end
        tests_run++; if (dataA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_data got %h want deadbeef", dataA); end
        tests_run++; if (errA !== 1'b0) begin fails++; $display("FAIL wr_err got %b want 0", errA); end
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", dataA); end
        tests_run++; if (lc !== 2) begin fails++; $display("FAIL rd_low_cycles got %0d want 2", lc); end
        tests_run++; if (fl !== 3) begin fails++; $display("FAIL rd_fall_latency got %0d want 3", fl); end
    endtask

    task automatic test_byte_ignored();
        int fl, lc;
        access(1'b0, 1'b0, 32'h0000_0012, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL byte_bits_read got %h want deadbeef", dataA); end
        access(1'b0, 1'b1, 32'h0000_0017, 32'hCAFE_F00D, fl, lc);
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL neighbour_intact got %h want deadbeef", dataA); end
        access(1'b0, 1'b0, 32'h0000_0014, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'hCAFE_F00D) begin fails++; $display("FAIL word5_read got %h want cafef00d", dataA); end
    endtask

    task automatic test_range();
        int fl, lc;
        access(1'b0, 1'b1, 32'h0000_0000, 32'hAAAA_5555, fl, lc);
        access(1'b0, 1'b1, 32'h0000_0400, 32'h0000_0001, fl, lc);
`ifdef RAM_RESP_RANGE_CHECK_EN
        tests_run++; if (errA !== 1'b1) begin fails++; $display("FAIL oor_wr_err got %b want 1", errA); end
        tests_run++; if (dataA !== 32'h0) begin fails++; $display("FAIL oor_wr_data got %h want 00000000", dataA); end
        access(1'b0, 1'b0, 32'h0000_0000, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'hAAAA_5555) begin fails++; $display("FAIL oor_word0 got %h want aaaa5555", dataA); end
        tests_run++; if (errA !== 1'b0) begin fails++; $display("FAIL inrange_err got %b want 0", errA); end
        access(1'b0, 1'b0, 32'h0000_0404, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'h0) begin fails++; $display("FAIL oor_rd_data got %h want 00000000", dataA); end
`else
        tests_run++; if (errA !== 1'b0) begin fails++; $display("FAIL wrap_wr_err got %b want 0", errA); end
        tests_run++; if (dataA !== 32'h0000_0001) begin fails++; $display("FAIL wrap_wr_data got %h want 00000001", dataA); end
        access(1'b0, 1'b0, 32'h0000_0000, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'h0000_0001) begin fails++; $display("FAIL wrap_word0 got %h want 00000001", dataA); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        bit         fell;
        rwIn = 1'b1; addrIn = 32'h0000_0018; dataIn = 32'h0BAD_F00D;
        trigA = ~trigA;
        fell = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!readyA) begin fell = 1'b1; break; end
        end
        tests_run++; if (fell !== 1'b1) begin fails++; $display("FAIL b2b_first_fall got %b want 1", fell); end
        // Second request toggled in the first BUSY cycle of the first access.
        rwIn = 1'b0;
        trigA = ~trigA;
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen[i] = readyA;
        end
        tests_run++; if (seen !== 6'b110010) begin fails++; $display("FAIL b2b_ready_seq got %b want 110010", seen); end
        tests_run++; if (dataA !== 32'h0BAD_F00D) begin fails++; $display("FAIL b2b_read_after_write got %h want 0badf00d", dataA); end
    endtask

    task automatic test_reset_abort();
        int fl, lc;
        bit fell;
        access(1'b0, 1'b1, 32'h0000_0020, 32'h55AA_55AA, fl, lc);
        rwIn = 1'b1; addrIn = 32'h0000_0020; dataIn = 32'h1234_5678;
        trigA = ~trigA;
        fell = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!readyA) begin fell = 1'b1; break; end
        end
        tests_run++; if (fell !== 1'b1) begin fails++; $display("FAIL abort_fall got %b want 1", fell); end
        tick();
        resetA = 1'b1; trigA = 1'b0;
        tick();
        tests_run++; if (readyA !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", readyA); end
        tests_run++; if (dataA !== 32'h0) begin fails++; $display("FAIL abort_data got %h want 00000000", dataA); end
        resetA = 1'b0;
        tick();
        access(1'b0, 1'b0, 32'h0000_0020, 32'h0, fl, lc);
        tests_run++; if (dataA !== 32'h55AA_55AA) begin fails++; $display("FAIL abort_no_commit got %h want 55aa55aa", dataA); end
        tests_run++; if (fl !== 3) begin fails++; $display("FAIL post_reset_latency got %0d want 3", fl); end
    endtask

    task automatic test_latency1();
        int fl, lc;
        access(1'b1, 1'b1, 32'h0000_0008, 32'h3C3C_3C3C, fl, lc);
        tests_run++; if (lc !== 1) begin fails++; $display("FAIL lat1_wr_low got %0d want 1", lc); end
        access(1'b1, 1'b0, 32'h0000_0008, 32'h0, fl, lc);
        tests_run++; if (lc !== 1) begin fails++; $display("FAIL lat1_rd_low got %0d want 1", lc); end
        tests_run++; if (fl !== 3) begin fails++; $display("FAIL lat1_fall_latency got %0d want 3", fl); end
        tests_run++; if (dataB !== 32'h3C3C_3C3C) begin fails++; $display("FAIL lat1_rd_data got %h want 3c3c3c3c", dataB); end
        tests_run++; if (errB !== 1'b0) begin fails++; $display("FAIL lat1_err got %b want 0", errB); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_ignored();
        test_range();
        test_back_to_back();
        test_reset_abort();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
